fir_output_sink: RTL
====================

// Module: fir_output_sink
// PURPOSE
//  Receiving end of the FIR sample interface. Captures each filter result
//  (FIR_output qualified by outputValid) and rounds/saturates it from the
//  full-precision accumulator width to sample width. Buffers results in a
//  small FIFO and drains them downstream over valid/ready.
//  Returns back-pressure (accept_ready_o) to the sample feeder and tracks
//  frame progress for the FIR datapath.
// PARAMETERS
//  IN_WIDTH    38      width of FIR accumulator output (signed)
//  OUT_WIDTH   16      width of delivered sample (signed)
//  FRAC_SHIFT  15      right-shift applied after rounding (coeff Q-format); must be >=1
//  FIFO_DEPTH  8       result FIFO entries; power of 2, >=2
//  FRAME_LEN   221184  samples per frame; done asserted after last drains
//  CNT_WIDTH   18      width of sample/drop counters; 2**CNT_WIDTH > FRAME_LEN
// PORTS
//  clkk            in   1          clock, all logic on rising edge
//  rst_n           in   1          synchronous, active-low reset
//  out_valid_i     in   1          FIR outputValid; 1-cycle pulse per result
//  fir_out_i       in   IN_WIDTH   FIR_output, signed; sampled when out_valid_i=1
//  accept_ready_o  out  1          feeder may issue next inputValid to FIR
//  m_valid_o       out  1          downstream sample valid
//  m_data_o        out  OUT_WIDTH  downstream sample, signed
//  m_ready_i       in   1          downstream accepts when m_valid_o & m_ready_i
//  sample_cnt_o    out  CNT_WIDTH  results accepted into pipeline this frame
//  drop_cnt_o      out  CNT_WIDTH  results dropped (arrived with no room)
//  overflow_o      out  1          sticky: >=1 drop since reset/clr_i
//  sat_o           out  1          sticky: >=1 saturation since reset/clr_i
//  done_o          out  1          level: FRAME_LEN samples delivered downstream
//  clr_i           in   1          sync clear of counters, flags, done; FIFO kept
// BEHAVIOUR
//  Reset (rst_n=0 at edge): FIFO empty, stage reg invalid, state RUN, all
//   outputs 0 except accept_ready_o=1. Reset mid-frame discards all buffered data.
//  Arithmetic: r = (fir_out_i + 2**(FRAC_SHIFT-1)) >>> FRAC_SHIFT, computed
//   in IN_WIDTH+1 bits (no wrap). Clamp to [-2**(OUT_WIDTH-1), 2**(OUT_WIDTH-1)-1].
//   Any clamp sets sat_o.
//  Pipeline: edge k samples out_valid_i -> stage reg valid; edge k+1 writes FIFO;
//   m_valid_o=1 after edge k+1 if FIFO was empty (latency 2). Stage reg never stalls.
//  Occupancy occ = fifo_count + stage_valid; accept_ready_o = (occ < FIFO_DEPTH-1)
//   (registered; one slot reserved for the in-flight result).
//  out_valid_i with occ == FIFO_DEPTH: result dropped, drop_cnt_o++, overflow_o=1,
//   sample_cnt_o unchanged. Drop test ignores a same-cycle pop (conservative).
//  FIFO push and pop in same cycle: both occur, count unchanged; pop on empty and
//   push on full are impossible by construction (assertion-checked).
//  m_data_o holds the FIFO head and is stable while m_valid_o & !m_ready_i.
//  FSM: RUN -> DONE on the pop delivering the FRAME_LEN-th sample; done_o=1 in DONE.
//   In DONE, out_valid_i is dropped and counted. DONE -> RUN on clr_i.
//   clr_i in RUN: zeroes counters/flags only.
//  clr_i coincident with out_valid_i: counter restarts at 1 (accepted sample counted).
//  Counters saturate at all-ones; no wrap.
// STRUCTURE
//  fir_sink_pkg: state_t enum {RUN, DONE}; function round_sat() returning value
//   and sat bit; localparams for rounding constant and clamp limits.
//  Sub-module sync_fifo #(WIDTH=OUT_WIDTH, DEPTH=FIFO_DEPTH): registered count,
//   full/empty, first-word-fall-through head. Top holds stage reg, FSM, counters.
// TESTING (FRAC_SHIFT=15, OUT_WIDTH=16, FIFO_DEPTH=8)
//  fir_out_i=16384, 16383, -16385 -> m_data_o = 1, 0, -1 at 2 cycles after each
//   pulse; sat_o=0.
//  fir_out_i=2**30, then -2**37 -> m_data_o = 0x7FFF, 0x8000; sat_o=1 stays 1
//   until clr_i.
//  m_ready_i=0, 10 pulses 1 cycle apart -> 8 delivered later; drop_cnt_o=2,
//   overflow_o=1; accept_ready_o=0 from occ=7.
//  FRAME_LEN=4, 5 pulses, m_ready_i=1 -> done_o rises on 4th pop; 5th dropped
//   (drop_cnt_o=1); clr_i -> done_o=0, counters 0.
//  rst_n=0 with 3 entries buffered -> next edge m_valid_o=0, counts 0,
//   accept_ready_o=1.
//  Random m_ready_i stalls, 1000 pulses, feeder gated by accept_ready_o ->
//   zero drops, output order and values match model.

Source files
------------

// File: rtl/fir_sink_pkg.sv
// Shared types and arithmetic for the FIR output sink: FSM states and the
// round-then-saturate step that narrows accumulator results to sample width.
package fir_sink_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam int DEF_IN_WIDTH   = 38;
    localparam int DEF_OUT_WIDTH  = 16;
    localparam int DEF_FRAC_SHIFT = 15;
    localparam int DEF_FIFO_DEPTH = 8;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] value;
    } round_t;

    // Operands are carried in 64 bits so the rounding add can never wrap
    // for any accumulator width up to 62 bits.
    function automatic round_t round_sat(input logic signed [63:0] x,
                                         input logic signed [63:0] round_k,
                                         input int                 frac_shift,
                                         input logic signed [63:0] sat_hi,
                                         input logic signed [63:0] sat_lo);
        round_t             r;
        logic signed [63:0] shifted;
        shifted = (x + round_k) >>> frac_shift;
        r.sat   = 1'b0;
        r.value = shifted;
        if (shifted > sat_hi) begin
            r.value = sat_hi;
            r.sat   = 1'b1;
        end else if (shifted < sat_lo) begin
            r.value = sat_lo;
            r.sat   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count/full/empty and a first-word-fall-
// through head: rd_data always shows the oldest entry while !empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clkk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;

    // NOTE: every variable assigned in an always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clkk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // NOTE: the storage array is not reset; pointers and count alone define which words are live.
    always_ff @(posedge clkk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

    a_no_push_full : assert property (@(posedge clkk) disable iff (!rst_n) !(push && full));
    a_no_pop_empty : assert property (@(posedge clkk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/fir_output_sink.sv
// Receiving end of the FIR sample interface: rounds/saturates each result,
// buffers it, drains it over valid/ready and tracks frame progress.
module fir_output_sink
    import fir_sink_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int FRAME_LEN  = 221184,
    parameter int CNT_WIDTH  = 18
) (
    input  logic                 clkk,
    input  logic                 rst_n,
    input  logic                 out_valid_i,
    input  logic [IN_WIDTH-1:0]  fir_out_i,
    output logic                 accept_ready_o,
    output logic                 m_valid_o,
    output logic [OUT_WIDTH-1:0] m_data_o,
    input  logic                 m_ready_i,
    output logic [CNT_WIDTH-1:0] sample_cnt_o,
    output logic [CNT_WIDTH-1:0] drop_cnt_o,
    output logic                 overflow_o,
    output logic                 sat_o,
    output logic                 done_o,
    input  logic                 clr_i
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic signed [63:0] ROUND_K = 64'sd1 <<< (FRAC_SHIFT - 1);
    localparam logic signed [63:0] SAT_HI  = (64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1;
    localparam logic signed [63:0] SAT_LO  = -(64'sd1 <<< (OUT_WIDTH - 1));
    localparam logic [CNT_WIDTH-1:0] FRAME_LAST = CNT_WIDTH'(FRAME_LEN - 1);

    state_t               state;
    logic                 stage_valid;
    logic [OUT_WIDTH-1:0] stage_data;
    logic [OCC_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_WIDTH-1:0] deliv_cnt;
    logic signed [63:0]   fir_ext;
    round_t               rnd;
    logic [OCC_W-1:0]     occ;
    logic [OCC_W-1:0]     occ_next;
    logic                 accept;
    logic                 drop;
    logic                 pop;
    logic                 frame_end;
    logic                 unused_bits;

    function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] c,
                                                  input logic                 en);
        return (en && (c != '1)) ? c + 1'b1 : c;
    endfunction

    assign fir_ext     = 64'(signed'(fir_out_i));
    assign unused_bits = ^{rnd.value[63:OUT_WIDTH], fifo_full};

    // The drop test uses pre-pop occupancy, so a same-cycle pop never rescues a result.
    always_comb begin
        rnd       = round_sat(fir_ext, ROUND_K, FRAC_SHIFT, SAT_HI, SAT_LO);
        pop       = m_valid_o && m_ready_i;
        occ       = fifo_count + OCC_W'(stage_valid);
        accept    = out_valid_i && (state == RUN) && (occ < OCC_W'(FIFO_DEPTH));
        drop      = out_valid_i && !accept;
        occ_next  = occ + OCC_W'(accept) - OCC_W'(pop);
        frame_end = pop && !clr_i && (deliv_cnt == FRAME_LAST);
    end

    always_ff @(posedge clkk) begin
        if (!rst_n) begin
            state          <= RUN;
            stage_valid    <= 1'b0;
            accept_ready_o <= 1'b1;
            sample_cnt_o   <= '0;
            drop_cnt_o     <= '0;
            deliv_cnt      <= '0;
            overflow_o     <= 1'b0;
            sat_o          <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            stage_valid    <= accept;
            accept_ready_o <= (occ_next < OCC_W'(FIFO_DEPTH - 1));
            sample_cnt_o   <= bump(clr_i ? '0 : sample_cnt_o, accept);
            drop_cnt_o     <= bump(clr_i ? '0 : drop_cnt_o, drop);
            deliv_cnt      <= bump(clr_i ? '0 : deliv_cnt, pop);
            overflow_o     <= (overflow_o && !clr_i) || drop;
            sat_o          <= (sat_o && !clr_i) || (accept && rnd.sat);
            case (state)
                RUN: begin
                    if (frame_end) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    if (clr_i) begin
                        state  <= RUN;
                        done_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clkk) begin
        if (accept) stage_data <= rnd.value[OUT_WIDTH-1:0];
    end

    sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clkk    (clkk),
        .rst_n   (rst_n),
        .push    (stage_valid),
        .wr_data (stage_data),
        .pop     (pop),
        .rd_data (m_data_o),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_valid_o = !fifo_empty;

endmodule
